// File: rtl/op_lut_reg_master.sv
// op_lut_reg_master
//   Head of the UDP register ring in front of the MPLS output-port-lookup
//   register block. Two requesters (A = host, B = local config/stats engine)
//   share the ring. The arbiter is round-robin and allows one transaction in
//   flight at a time. The granted requester receives read data or error
//   status when the ring returns, or when the timeout expires.
//
// Ports
//   clk, reset_n                   clock, async active-low reset
//   a_* / b_*  (in)                req, rd_wr_L (1=read), addr, wdata
//   a_* / b_*  (out)               done pulse, rdata, err (held until next done)
//   reg_*_out                      ring request (issued for one cycle, else 0)
//   reg_*_in                       ring return from the ring tail
//   timeout_count                  saturating count of timed-out transactions
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no transaction; grant and latch a request when one is present
// ISSUE  | drive the ring request on the next edge, load the timer
// WAIT   | wait for a return carrying our src tag, or for the timer to expire
// RESP   | done pulse is visible; hand the grant history to the arbiter
module op_lut_reg_master #(
  parameter int                           UDP_REG_SRC_WIDTH = 2,
  parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = 2'd1,
  parameter int                           TIMEOUT           = 1023,
  parameter int                           ADDR_WIDTH        = 23,
  parameter int                           DATA_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,

  input  logic                         a_req,
  input  logic                         a_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]        a_addr,
  input  logic [DATA_WIDTH-1:0]        a_wdata,
  output logic                         a_done,
  output logic [DATA_WIDTH-1:0]        a_rdata,
  output logic                         a_err,

  input  logic                         b_req,
  input  logic                         b_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0]        b_addr,
  input  logic [DATA_WIDTH-1:0]        b_wdata,
  output logic                         b_done,
  output logic [DATA_WIDTH-1:0]        b_rdata,
  output logic                         b_err,

  output logic                         reg_req_out,
  output logic                         reg_ack_out,
  output logic                         reg_rd_wr_L_out,
  output logic [ADDR_WIDTH-1:0]        reg_addr_out,
  output logic [DATA_WIDTH-1:0]        reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,

  input  logic                         reg_req_in,
  input  logic                         reg_ack_in,
  input  logic                         reg_rd_wr_L_in,
  input  logic [ADDR_WIDTH-1:0]        reg_addr_in,
  input  logic [DATA_WIDTH-1:0]        reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

  output logic [15:0]                  timeout_count
);

  localparam logic [DATA_WIDTH-1:0] BAD_DATA  = DATA_WIDTH'(32'hDEAD_BEEF);
  localparam logic [9:0]            TMO_LOAD  = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    grant_b_q;       // requester owning the current transaction
  logic                    last_grant_b_q;  // requester served most recently
  logic                    rd_wr_L_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [9:0]              timer_q;

  logic                    any_req;
  logic                    pick_b;
  logic                    ret_ok;
  logic                    tmo;
  logic                    issue;
  logic                    finish;
  logic                    fin_err;
  logic [DATA_WIDTH-1:0]   fin_data;
  logic                    tmo_hit;

  // The ring echoes rd/wr and address back, but the src tag alone identifies
  // our return, so the echoed fields are not needed.
  logic unused_ring;
  assign unused_ring = ^{reg_rd_wr_L_in, reg_addr_in};

  assign any_req = a_req | b_req;
  // B wins only when A is idle, or when both are requesting and A was served last.
  assign pick_b  = b_req & (~a_req | ~last_grant_b_q);
  assign ret_ok  = reg_req_in && (reg_src_in == SRC_ID);
  // The timer is loaded with TIMEOUT-1 on ISSUE. Reaching zero in WAIT marks
  // the TIMEOUT-th WAIT cycle.
  assign tmo     = (timer_q == 10'd0);

  assign reg_ack_out = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (ret_ok || tmo) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A valid return takes priority over the timeout in the same cycle.
  always_comb begin
    issue    = 1'b0;
    finish   = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    tmo_hit  = 1'b0;
    case (state_q)
      S_ISSUE: issue = 1'b1;
      S_WAIT: begin
        if (ret_ok) begin
          finish   = 1'b1;
          fin_err  = ~reg_ack_in;
          fin_data = reg_ack_in ? reg_data_in : BAD_DATA;
        end else if (tmo) begin
          finish   = 1'b1;
          fin_err  = 1'b1;
          fin_data = BAD_DATA;
          tmo_hit  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_b_q       <= 1'b0;
      last_grant_b_q  <= 1'b1;
      rd_wr_L_q       <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      timer_q         <= '0;
      reg_req_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      a_done          <= 1'b0;
      a_rdata         <= '0;
      a_err           <= 1'b0;
      b_done          <= 1'b0;
      b_rdata         <= '0;
      b_err           <= 1'b0;
      timeout_count   <= '0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        grant_b_q <= pick_b;
        rd_wr_L_q <= pick_b ? b_rd_wr_L : a_rd_wr_L;
        addr_q    <= pick_b ? b_addr    : a_addr;
        wdata_q   <= pick_b ? b_wdata   : a_wdata;
      end

      if (state_q == S_RESP) last_grant_b_q <= grant_b_q;

      if (issue)                            timer_q <= TMO_LOAD;
      else if (state_q == S_WAIT && !tmo)   timer_q <= timer_q - 10'd1;

      // The ring is driven only during the issue cycle and is zero at all other times.
      reg_req_out     <= issue;
      reg_rd_wr_L_out <= issue & rd_wr_L_q;
      reg_addr_out    <= issue ? addr_q  : '0;
      reg_data_out    <= issue ? wdata_q : '0;
      reg_src_out     <= issue ? SRC_ID  : '0;

      a_done <= finish & ~grant_b_q;
      b_done <= finish &  grant_b_q;
      if (finish && !grant_b_q) begin
        a_rdata <= fin_data;
        a_err   <= fin_err;
      end
      if (finish && grant_b_q) begin
        b_rdata <= fin_data;
        b_err   <= fin_err;
      end

      if (tmo_hit && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_op_lut_reg_master.sv
module tb_op_lut_reg_master;
  localparam int AW = 23;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req, a_rd_wr_L, b_req, b_rd_wr_L;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_done, a_err, b_done, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0]    reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [1:0]    reg_src_in;
  logic [15:0]   timeout_count;

  int total = 0;
  int bad   = 0;
  int cyc;

  op_lut_reg_master #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_rd_wr_L(a_rd_wr_L), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_rd_wr_L(b_rd_wr_L), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input string tag, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (reg_req_out) begin
        seen   = 1'b1;
        cycles = i;
        break;
      end
    end
    check({tag, "_issue_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic ring_ret(input logic ack, input logic [31:0] data, input logic [1:0] src);
    reg_req_in     = 1'b1;
    reg_ack_in     = ack;
    reg_data_in    = data;
    reg_src_in     = src;
    reg_rd_wr_L_in = 1'b1;
    reg_addr_in    = '0;
    tick(1);
    reg_req_in  = 1'b0;
    reg_ack_in  = 1'b0;
    reg_data_in = '0;
    reg_src_in  = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 0; a_rd_wr_L = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_rd_wr_L = 0; b_addr = '0; b_wdata = '0;
    reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;

    tick(3);
    check("rst_req_out", 32'(reg_req_out), 0);
    check("rst_src_out", 32'(reg_src_out), 0);
    check("rst_done",    32'({a_done, b_done}), 0);
    check("rst_rdata",   a_rdata | b_rdata, 0);
    check("rst_tmo_cnt", 32'(timeout_count), 0);
    reset_n = 1'b1;

    // Both requesting out of reset: A goes first, then the grants alternate strictly.
    a_req = 1; a_rd_wr_L = 1; a_addr = 23'h000011;
    b_req = 1; b_rd_wr_L = 1; b_addr = 23'h000022;
    for (int k = 0; k < 4; k++) begin
      wait_issue("rr", cyc);
      check("rr_addr", 32'(reg_addr_out), (k % 2) ? 32'h22 : 32'h11);
      ring_ret(1'b1, 32'h100 + 32'(k), 2'd1);
      check("rr_a_done", 32'(a_done), (k % 2) ? 0 : 1);
      check("rr_b_done", 32'(b_done), (k % 2) ? 1 : 0);
      if (k == 3) begin a_req = 0; b_req = 0; end
      tick(1);
      check("rr_done_pulse", 32'({a_done, b_done}), 0);
    end
    check("rr_a_rdata", a_rdata, 32'h102);
    check("rr_b_rdata", b_rdata, 32'h103);

    // Read from A. The ring acks 5 cycles after the issue.
    a_req = 1; a_rd_wr_L = 1; a_addr = 23'h000203;
    wait_issue("rd", cyc);
    check("rd_issue_lat", 32'(cyc), 2);
    check("rd_rw_out",    32'(reg_rd_wr_L_out), 1);
    check("rd_addr_out",  32'(reg_addr_out), 32'h203);
    check("rd_src_out",   32'(reg_src_out), 1);
    check("rd_ack_out",   32'(reg_ack_out), 0);
    tick(1);
    check("rd_req_pulse", 32'(reg_req_out), 0);
    tick(3);
    ring_ret(1'b1, 32'h1234_5678, 2'd1);
    check("rd_done",  32'(a_done), 1);
    check("rd_rdata", a_rdata, 32'h1234_5678);
    check("rd_err",   32'(a_err), 0);
    a_req = 0;
    tick(1);
    check("rd_done_pulse", 32'(a_done), 0);
    check("rd_rdata_hold", a_rdata, 32'h1234_5678);

    // Write from B that the ring does not claim (ack=0).
    b_req = 1; b_rd_wr_L = 0; b_addr = 23'h000210; b_wdata = 32'h0000_0400;
    wait_issue("wr", cyc);
    check("wr_rw_out",   32'(reg_rd_wr_L_out), 0);
    check("wr_addr_out", 32'(reg_addr_out), 32'h210);
    check("wr_data_out", reg_data_out, 32'h0000_0400);
    tick(1);
    ring_ret(1'b0, 32'h0000_0400, 2'd1);
    check("wr_nack_done",  32'(b_done), 1);
    check("wr_nack_err",   32'(b_err), 1);
    check("wr_nack_rdata", b_rdata, 32'hDEAD_BEEF);
    check("wr_nack_adone", 32'(a_done), 0);
    b_req = 0;
    tick(1);

    // Acked write: rdata holds the echoed write data, and A's held data is untouched.
    b_req = 1; b_wdata = 32'h0000_55AA;
    wait_issue("wr2", cyc);
    ring_ret(1'b1, 32'h0000_55AA, 2'd1);
    check("wr_ack_err",   32'(b_err), 0);
    check("wr_ack_rdata", b_rdata, 32'h0000_55AA);
    check("wr_a_hold",    a_rdata, 32'h1234_5678);
    b_req = 0;
    tick(1);

    // The ring never returns: done comes exactly 8 cycles after WAIT entry.
    a_req = 1; a_rd_wr_L = 1; a_addr = 23'h000030;
    wait_issue("tmo", cyc);
    tick(7);
    check("tmo_early", 32'(a_done), 0);
    tick(1);
    check("tmo_done",  32'(a_done), 1);
    check("tmo_err",   32'(a_err), 1);
    check("tmo_rdata", a_rdata, 32'hDEAD_BEEF);
    check("tmo_count", 32'(timeout_count), 1);
    a_req = 0;
    tick(1);

    // A return that lands on the timeout cycle is accepted and no timeout is counted.
    a_req = 1;
    wait_issue("tmo2", cyc);
    tick(7);
    ring_ret(1'b1, 32'hCAFE_0001, 2'd1);
    check("tmo2_done",  32'(a_done), 1);
    check("tmo2_err",   32'(a_err), 0);
    check("tmo2_rdata", a_rdata, 32'hCAFE_0001);
    check("tmo2_count", 32'(timeout_count), 1);
    a_req = 0;
    tick(1);

    // A return carrying a foreign src tag is ignored.
    a_req = 1; a_addr = 23'h000040;
    wait_issue("src", cyc);
    tick(1);
    ring_ret(1'b1, 32'hBAD0_0002, 2'd2);
    check("src_ignored", 32'(a_done), 0);
    tick(1);
    ring_ret(1'b1, 32'h0000_5005, 2'd1);
    check("src_done",  32'(a_done), 1);
    check("src_rdata", a_rdata, 32'h0000_5005);
    a_req = 0;
    tick(1);

    // Reset asserted during WAIT clears all outputs immediately, and a late return is dropped.
    a_req = 1; a_addr = 23'h000050;
    wait_issue("mrst", cyc);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_req_out", 32'(reg_req_out), 0);
    check("mrst_addr",    32'(reg_addr_out), 0);
    check("mrst_rdata",   a_rdata, 0);
    check("mrst_count",   32'(timeout_count), 0);
    check("mrst_done",    32'({a_done, b_done}), 0);
    a_req = 0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    ring_ret(1'b1, 32'h0000_0077, 2'd1);
    check("late_ret_done", 32'({a_done, b_done}), 0);
    tick(2);
    check("late_ret_idle", 32'({reg_req_out, a_done}), 0);

    a_req = 1; a_addr = 23'h000060;
    wait_issue("post", cyc);
    check("post_lat", 32'(cyc), 2);
    tick(1);
    ring_ret(1'b1, 32'h6060_6060, 2'd1);
    check("post_done",  32'(a_done), 1);
    check("post_rdata", a_rdata, 32'h6060_6060);
    check("post_err",   32'(a_err), 0);
    a_req = 0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
